// File: rtl/seg7_scan_decoder.sv
// Loop-back monitor for a multiplexed active-low 7-segment bus: waits for each
// digit enable to settle, samples the segment lines once and decodes them to BCD.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     an_n,
    input  logic [6:0]                seg_n,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_done,
    output logic                      err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE,
        ST_HELD
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_DIGITS-1:0]     r_an_prev;
    logic [CW-1:0]             r_stable_cnt;
    logic [CW-1:0]             w_stable_cnt_nxt;
    logic [NUM_DIGITS-1:0]     r_seen;
    logic [NUM_DIGITS-1:0]     w_seen_nxt;
    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [4*NUM_DIGITS-1:0]   w_digits_nxt;
    logic [NUM_DIGITS-1:0]     r_valid;
    logic [NUM_DIGITS-1:0]     w_valid_nxt;
    logic                      r_frame_done;
    logic                      w_frame_done_nxt;
    logic                      r_err;
    logic                      w_err_nxt;

    logic                      w_same;
    logic                      w_fire;
    logic [NUM_DIGITS-1:0]     w_sel;
    logic                      w_one_hot;
    logic                      w_multi;
    logic [3:0]                w_dec_val;
    logic                      w_dec_legal;
    logic                      w_dec_blank;

    assign w_same    = (an_n == r_an_prev);
    assign w_sel     = ~an_n;
    assign w_one_hot = ($countones(w_sel) == 1);
    assign w_multi   = ($countones(w_sel) > 1);
    // The capture edge is the one on which stable_cnt would reach SETTLE_CYCLES
    assign w_fire    = (r_state == ST_WAIT) && w_same &&
                       (r_stable_cnt == CW'(SETTLE_CYCLES - 1));

    always_comb begin
        w_dec_val   = 4'hF;
        w_dec_legal = 1'b1;
        w_dec_blank = 1'b0;
        unique case (seg_n)
            7'b0000001: w_dec_val = 4'd0;
            7'b1001111: w_dec_val = 4'd1;
            7'b0010010: w_dec_val = 4'd2;
            7'b0000110: w_dec_val = 4'd3;
            7'b1001100: w_dec_val = 4'd4;
            7'b0100100: w_dec_val = 4'd5;
            7'b0100000: w_dec_val = 4'd6;
            7'b0001111: w_dec_val = 4'd7;
            7'b0000000: w_dec_val = 4'd8;
            7'b0000100: w_dec_val = 4'd9;
            7'b1111111: w_dec_blank = 1'b1;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_WAIT:    if (w_fire) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = w_same ? ST_HELD : ST_WAIT;
            ST_HELD:    if (!w_same) w_state_nxt = ST_WAIT;
            default:    w_state_nxt = ST_WAIT;
        endcase
    end

    always_comb begin
        if (!w_same)
            w_stable_cnt_nxt = '0;
        else if (r_stable_cnt < CW'(SETTLE_CYCLES))
            w_stable_cnt_nxt = r_stable_cnt + CW'(1);
        else
            w_stable_cnt_nxt = r_stable_cnt;
    end

    always_comb begin
        w_digits_nxt     = r_digits;
        w_valid_nxt      = r_valid;
        w_seen_nxt       = r_seen;
        w_frame_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;
        if (w_fire && w_one_hot) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_sel[i]) begin
                    if (w_dec_legal) begin
                        w_digits_nxt[4*i +: 4] = w_dec_val;
                        w_valid_nxt[i]         = !w_dec_blank;
                    end else begin
                        w_valid_nxt[i]         = 1'b0;
                    end
                end
            end
            w_err_nxt  = !w_dec_legal;
            w_seen_nxt = r_seen | w_sel;
            if (w_seen_nxt == '1) begin
                w_frame_done_nxt = 1'b1;
                w_seen_nxt       = '0;
            end
        end else if (w_fire && w_multi) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_WAIT;
            r_an_prev    <= '1;
            r_stable_cnt <= '0;
            r_seen       <= '0;
            r_digits     <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_an_prev    <= an_n;
            r_stable_cnt <= w_stable_cnt_nxt;
            r_seen       <= w_seen_nxt;
            r_digits     <= w_digits_nxt;
            r_valid      <= w_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: the driver predicts each capture event
// and its cycle; the monitor checks every output on every falling edge.
module tb_seg7_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  an_n = '1;
    logic [6:0]    seg_n = 7'h7F;
    logic [4*N-1:0] digits;
    logic [N-1:0]  digit_valid;
    logic          frame_done;
    logic          err;

    seg7_scan_decoder #(.NUM_DIGITS(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk),
        .rst(rst),
        .an_n(an_n),
        .seg_n(seg_n),
        .digits(digits),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int             cyc;
        logic [4*N-1:0] d;
        logic [N-1:0]   v;
        logic           fd;
        logic           er;
    } exp_t;

    exp_t           q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    bit             rst_q = 1'b0;

    logic [4*N-1:0] m_d = '0;
    logic [N-1:0]   m_v = '0;
    logic [N-1:0]   m_seen = '0;
    logic [N-1:0]   last_an = '1;

    logic [6:0] enc [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    // -1 illegal, 15 blank, otherwise the BCD value
    function automatic int decode(input logic [6:0] s);
        if (s == 7'b1111111) return 15;
        for (int k = 0; k < 10; k++)
            if (enc[k] == s) return k;
        return -1;
    endfunction

    task automatic scan(input logic [N-1:0] an, input logic [6:0] seg,
                        input int dwell, input bit toggle);
        logic [N-1:0] sel;
        exp_t         e;
        int           dv;
        an_n  = an;
        seg_n = seg;
        sel   = ~an;
        if (an != last_an && dwell >= S + 1 && sel != '0) begin
            e.fd = 1'b0;
            e.er = 1'b0;
            if ($countones(sel) == 1) begin
                dv = decode(seg);
                for (int i = 0; i < N; i++) begin
                    if (sel[i]) begin
                        if (dv < 0) begin
                            m_v[i] = 1'b0;
                            e.er   = 1'b1;
                        end else begin
                            m_d[4*i +: 4] = 4'(dv);
                            m_v[i]        = (dv != 15);
                        end
                    end
                end
                m_seen = m_seen | sel;
                if (m_seen == '1) begin
                    e.fd   = 1'b1;
                    m_seen = '0;
                end
            end else begin
                e.er = 1'b1;
            end
            e.cyc = cyc + 1 + S;
            e.d   = m_d;
            e.v   = m_v;
            q.push_back(e);
        end
        last_an = an;
        for (int k = 0; k < dwell; k++) begin
            @(negedge clk);
            if (toggle && k >= S) seg_n = 7'($urandom);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        an_n = '1;
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        m_d     = '0;
        m_v     = '0;
        m_seen  = '0;
        last_an = '1;
    endtask

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_q = rst;
    end

    logic [4*N-1:0] cur_d = '0;
    logic [N-1:0]   cur_v = '0;

    always @(negedge clk) begin
        logic e_fd;
        logic e_er;
        exp_t e;
        e_fd = 1'b0;
        e_er = 1'b0;
        if (cyc > 0) begin
            if (rst_q) begin
                cur_d = '0;
                cur_v = '0;
            end else if (q.size() > 0 && q[0].cyc == cyc) begin
                e     = q.pop_front();
                cur_d = e.d;
                cur_v = e.v;
                e_fd  = e.fd;
                e_er  = e.er;
            end
            chk("digits", 32'(digits), 32'(cur_d));
            chk("digit_valid", 32'(digit_valid), 32'(cur_v));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("err", 32'(err), 32'(e_er));
        end
    end

    initial begin
        do_reset(3);

        // full frame 1,2,3,4 then every numeral across the digits
        for (int i = 0; i < 4; i++)
            scan(~(4'b0001 << i), enc[i+1], 8, 1'b0);
        for (int v = 0; v < 10; v++)
            scan(~(4'b0001 << (v % 4)), enc[v], 6, 1'b0);

        // short dwell produces no capture, then minimum-latency capture
        scan(4'b1110, enc[7], 3, 1'b0);
        scan(4'b1101, enc[5], 8, 1'b0);
        scan(4'b1110, enc[6], S + 1, 1'b0);

        // blank then illegal on digit 2
        scan(4'b1011, 7'b1111111, 8, 1'b0);
        scan(4'b1111, 7'b1111111, 2, 1'b0);
        scan(4'b1011, 7'b0110110, 8, 1'b0);

        // multi-enable and all-off
        scan(4'b1100, enc[8], 20, 1'b0);
        scan(4'b1111, enc[8], 20, 1'b0);

        // reset mid-frame, then full scan
        scan(4'b1110, enc[9], 8, 1'b0);
        scan(4'b1101, enc[0], 8, 1'b0);
        do_reset(2);
        for (int i = 0; i < 4; i++)
            scan(~(4'b0001 << i), enc[i+5], 8, 1'b0);

        // long dwell with segments toggling after the capture
        scan(4'b1110, enc[3], 50, 1'b1);
        scan(4'b1111, 7'b1111111, 4, 1'b0);

        // random patterns, including illegal ones
        for (int j = 0; j < 12; j++) begin
            scan(~(4'b0001 << (j % 4)),
                 ($urandom_range(0, 2) == 0) ? 7'($urandom) : enc[$urandom_range(0, 9)],
                 7, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
